interval_timer: RTL and testbench
=================================

INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 SHALL have parameter CLOCKS_PER_SECOND, default 50000000, clock cycles per one-second tick (minimum 2).
REQ-002 SHALL have parameter DEFAULT_BASE, default 6, reset value of the base interval in seconds.
REQ-003 SHALL have parameter DEFAULT_EXTENDED, default 3, reset value of the extended interval in seconds.
REQ-004 SHALL have parameter DEFAULT_YELLOW, default 2, reset value of the yellow interval in seconds.
REQ-005 SHALL have port: clock  in  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port: reprogram  in  1  write time_value into the register chosen by time_parameter_selector.
REQ-008 SHALL have port: time_parameter_selector  in  2  00 base, 01 extended, 10 yellow, 11 reserved.
REQ-009 SHALL have port: time_value  in  4  new interval in seconds, 1..15.
REQ-010 SHALL have port: start_timer  in  1  single-cycle request from the light controller FSM to begin timing.
REQ-011 SHALL have port: interval_select  in  2  00 base, 01 extended, 10 yellow, 11 double base.
REQ-012 SHALL have port: expired  out  1  one-cycle pulse at the end of the interval.
REQ-013 SHALL have port: busy  out  1  high while timing is in progress.
REQ-014 SHALL have port: seconds_left  out  5  remaining whole seconds, 0 when idle.

Function
REQ-015 SHALL implement two states: IDLE (busy=0) and COUNT (busy=1).
REQ-016 On start_timer=1 in either state, SHALL load seconds_left with the selected interval, clear the divider, and enter COUNT on the next edge; a start during COUNT restarts timing.
REQ-017 Double base SHALL equal 2 x base register, 5-bit result, no overflow (max 30).
REQ-018 The divider SHALL count 0..CLOCKS_PER_SECOND-1 only in COUNT and SHALL produce a tick in the cycle it equals CLOCKS_PER_SECOND-1.
REQ-019 Each tick SHALL decrement seconds_left by 1.
REQ-020 The tick that takes seconds_left from 1 to 0 SHALL return the block to IDLE and assert expired for exactly one cycle.
REQ-021 Latency: expired SHALL be high N x CLOCKS_PER_SECOND cycles after the cycle in which start_timer was sampled, where N is the loaded value.
REQ-022 reprogram=1 with selector 00/01/10 and time_value non-zero SHALL update that register on the next edge.
REQ-023 reprogram with selector 11 or time_value=0 SHALL leave all registers unchanged.
REQ-024 Any reprogram=1 SHALL abort timing: return to IDLE, seconds_left=0, and no expired pulse.
REQ-025 reprogram and start_timer in the same cycle: reprogram SHALL win and start_timer SHALL be ignored.
REQ-026 A new interval value SHALL affect only starts after the write; an in-flight count is never altered except by abort.
REQ-027 start_timer with a selected value of 0 SHALL be impossible by construction (REQ-023).

Reset
REQ-028 reset SHALL put the FSM in IDLE and set divider=0, seconds_left=0, expired=0, busy=0.
REQ-029 reset SHALL restore the base, extended and yellow registers to their DEFAULT_* values.
REQ-030 reset SHALL take priority over reprogram and start_timer, including mid-count, with no expired pulse.

Structure
REQ-031 Selector/interval encodings and state encodings SHALL live in shared package traffic_pkg, which the light controller also uses.
REQ-032 The divider SHALL be a sub-module named second_tick_gen (enable, clear, tick).

Verification
REQ-033 CLOCKS_PER_SECOND=4, reset, start with yellow selected -> expired one cycle at 8 cycles after start, busy for 8 cycles, seconds_left 2,1,0.
REQ-034 reprogram selector 00 value 9, then start with double base -> seconds_left loads 18, expired after 72 cycles.
REQ-035 Start base, reprogram at cycle 5 -> busy drops, no expired pulse ever, new base value stored.
REQ-036 reprogram with selector 11 or time_value 0 -> all three registers keep their prior values.
REQ-037 Restart at cycle 10 of a base count -> expired at 24 cycles after the restart, single pulse only.
REQ-038 reset asserted mid-count after reprogram of extended to 7 -> outputs zero, extended reads back as 3 via a subsequent 12-cycle count.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Encodings shared by the interval timer and the light
//               controller: register selector, interval select, timer
//               state codes and a helper for the double-base interval.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  typedef logic [1:0] param_sel_t;
  typedef logic [1:0] interval_sel_t;

  // Register selector used with reprogram
  localparam param_sel_t SEL_BASE     = 2'b00;
  localparam param_sel_t SEL_EXTENDED = 2'b01;
  localparam param_sel_t SEL_YELLOW   = 2'b10;
  localparam param_sel_t SEL_RESERVED = 2'b11;

  // Interval chosen when timing starts
  localparam interval_sel_t INT_BASE        = 2'b00;
  localparam interval_sel_t INT_EXTENDED    = 2'b01;
  localparam interval_sel_t INT_YELLOW      = 2'b10;
  localparam interval_sel_t INT_DOUBLE_BASE = 2'b11;

  // Timer FSM states
  localparam logic [0:0] TMR_IDLE  = 1'b0;
  localparam logic [0:0] TMR_COUNT = 1'b1;

  // 2 x a 4-bit interval always fits in 5 bits (max 30)
  function automatic logic [4:0] double_interval(input logic [3:0] value);
    return {value, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/interval_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer_if
// Description : Control/status bundle between the light controller (master)
//               and the interval timer (slave).
//               reprogram / time_parameter_selector / time_value : register write
//               start_timer / interval_select                     : start request
//               expired / busy / seconds_left                     : timer status
// Revision    : 1.0 - initial release
// ============================================================================
interface interval_timer_if;
  import traffic_pkg::*;

  logic          reprogram;
  param_sel_t    time_parameter_selector;
  logic [3:0]    time_value;
  logic          start_timer;
  interval_sel_t interval_select;
  logic          expired;
  logic          busy;
  logic [4:0]    seconds_left;

  modport master (
    output reprogram, time_parameter_selector, time_value,
    output start_timer, interval_select,
    input  expired, busy, seconds_left
  );

  modport slave (
    input  reprogram, time_parameter_selector, time_value,
    input  start_timer, interval_select,
    output expired, busy, seconds_left
  );

endinterface
`default_nettype wire

// File: rtl/second_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : second_tick_gen
// Description : Clock divider producing a one-cycle tick every
//               CLOCKS_PER_SECOND enabled cycles.
//               clock, reset : system clock, synchronous active-high reset
//               enable       : count this cycle
//               clear        : restart the count from zero (wins over enable)
//               tick         : high in the cycle the count is at its last value
// Revision    : 1.0 - initial release
// ============================================================================
module second_tick_gen #(
  parameter int CLOCKS_PER_SECOND = 50000000
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic enable,
  input  wire logic clear,
  output logic      tick
);

  localparam int                 c_div_w    = $clog2(CLOCKS_PER_SECOND);
  localparam logic [c_div_w-1:0] c_terminal = c_div_w'(CLOCKS_PER_SECOND - 1);

  logic [c_div_w-1:0] r_count;

  assign tick = enable && (r_count == c_terminal);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= tick ? '0 : r_count + c_div_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer
// Description : Programmable seconds timer for the traffic light controller.
//               Holds base / extended / yellow intervals, counts the selected
//               one down once per second and pulses expired at the end.
//               clock, reset : system clock, synchronous active-high reset
//               bus (slave)  : reprogram/start requests in, expired/busy/
//                              seconds_left status out
// Revision    : 1.0 - initial release
// ============================================================================
module interval_timer
  import traffic_pkg::*;
#(
  parameter int CLOCKS_PER_SECOND = 50000000,
  parameter int DEFAULT_BASE      = 6,
  parameter int DEFAULT_EXTENDED  = 3,
  parameter int DEFAULT_YELLOW    = 2
) (
  input wire logic         clock,
  input wire logic         reset,
  interval_timer_if.slave  bus
);

  localparam logic [3:0] c_default_base     = 4'(DEFAULT_BASE);
  localparam logic [3:0] c_default_extended = 4'(DEFAULT_EXTENDED);
  localparam logic [3:0] c_default_yellow   = 4'(DEFAULT_YELLOW);

  logic [0:0] r_state;
  logic [4:0] r_seconds_left;
  logic [3:0] r_base;
  logic [3:0] r_extended;
  logic [3:0] r_yellow;

  logic       w_tick;
  logic       w_counting;
  logic       w_write_ok;
  logic       w_start;
  logic [4:0] w_selected;

  assign w_counting = (r_state == TMR_COUNT);
  // Zero or reserved-slot writes are dropped so a loaded interval is never 0
  assign w_write_ok = bus.reprogram
                   && (bus.time_parameter_selector != SEL_RESERVED)
                   && (bus.time_value != 4'd0);
  // Any reprogram aborts, so it also masks a simultaneous start
  assign w_start    = bus.start_timer && !bus.reprogram;

  always_comb begin
    w_selected = 5'd0;
    case (bus.interval_select)
      INT_BASE:     w_selected = {1'b0, r_base};
      INT_EXTENDED: w_selected = {1'b0, r_extended};
      INT_YELLOW:   w_selected = {1'b0, r_yellow};
      default:      w_selected = double_interval(r_base);
    endcase
  end

  second_tick_gen #(
    .CLOCKS_PER_SECOND (CLOCKS_PER_SECOND)
  ) u_second_tick_gen (
    .clock  (clock),
    .reset  (reset),
    .enable (w_counting),
    .clear  (w_start || bus.reprogram),
    .tick   (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= TMR_IDLE;
      r_seconds_left <= 5'd0;
      r_base         <= c_default_base;
      r_extended     <= c_default_extended;
      r_yellow       <= c_default_yellow;
    end else begin
      if (w_write_ok) begin
        case (bus.time_parameter_selector)
          SEL_BASE:     r_base     <= bus.time_value;
          SEL_EXTENDED: r_extended <= bus.time_value;
          default:      r_yellow   <= bus.time_value;
        endcase
      end

      if (bus.reprogram) begin
        r_state        <= TMR_IDLE;
        r_seconds_left <= 5'd0;
      end else if (w_start) begin
        r_state        <= TMR_COUNT;
        r_seconds_left <= w_selected;
      end else if (w_counting && w_tick) begin
        r_seconds_left <= r_seconds_left - 5'd1;
        if (r_seconds_left == 5'd1) begin
          r_state <= TMR_IDLE;
        end
      end
    end
  end

  // Pulse in the final tick cycle unless that cycle is reset, aborted or
  // restarted, in which case the interval never completes.
  assign bus.expired      = w_counting && w_tick && (r_seconds_left == 5'd1)
                         && !reset && !bus.reprogram && !bus.start_timer;
  assign bus.busy         = w_counting;
  assign bus.seconds_left = r_seconds_left;

endmodule
`default_nettype wire

// File: tb/tb_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_interval_timer
// Description : Directed self-checking bench for interval_timer with
//               CLOCKS_PER_SECOND = 4 and default intervals 6/3/2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interval_timer;
  import traffic_pkg::*;

  localparam int CPS = 4;

  logic clock;
  logic reset;
  int   tests;
  int   failures;

  interval_timer_if bus ();

  interval_timer #(
    .CLOCKS_PER_SECOND (CPS),
    .DEFAULT_BASE      (6),
    .DEFAULT_EXTENDED  (3),
    .DEFAULT_YELLOW    (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " seconds_left"}, 32'(bus.seconds_left), 32'd0);
    check({tag, " expired"}, 32'(bus.expired), 32'd0);
  endtask

  task automatic do_start(input interval_sel_t sel);
    bus.start_timer     = 1'b1;
    bus.interval_select = sel;
    next_cycle();
    bus.start_timer     = 1'b0;
  endtask

  task automatic do_prog(input param_sel_t sel, input logic [3:0] val);
    bus.reprogram               = 1'b1;
    bus.time_parameter_selector = sel;
    bus.time_value              = val;
    next_cycle();
    bus.reprogram               = 1'b0;
  endtask

  // Called in cycle 1 after a start: follows the full count of n seconds
  task automatic run_count(input string tag, input int n);
    int pulses;
    int sl_err;
    int busy_err;
    int pulse_at;
    pulses = 0; sl_err = 0; busy_err = 0; pulse_at = -1;
    for (int k = 1; k <= n * CPS; k++) begin
      #1;
      if (bus.seconds_left !== 5'(n - (k - 1) / CPS)) sl_err++;
      if (bus.busy !== 1'b1) busy_err++;
      if (bus.expired === 1'b1) begin
        pulses++;
        pulse_at = k;
      end
      @(posedge clock);
      #1;
    end
    check({tag, " seconds_left trace errors"}, 32'(sl_err), 32'd0);
    check({tag, " busy trace errors"}, 32'(busy_err), 32'd0);
    check({tag, " expired pulses"}, 32'(pulses), 32'd1);
    check({tag, " expired cycle"}, 32'(pulse_at), 32'(n * CPS));
    #1;
    check_idle({tag, " after"});
  endtask

  task automatic watch_no_pulse(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      #1;
      if (bus.expired === 1'b1) pulses++;
      next_cycle();
    end
    check({tag, " stray pulses"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    reset                       = 1'b1;
    bus.reprogram               = 1'b0;
    bus.time_parameter_selector = SEL_BASE;
    bus.time_value              = 4'd0;
    bus.start_timer             = 1'b0;
    bus.interval_select         = INT_BASE;

    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    check_idle("reset");

    // Yellow (2 s): seconds_left 2,1, expired at cycle 8
    do_start(INT_YELLOW);
    run_count("yellow", 2);

    // Base = 9, double base loads 18, expired after 72 cycles
    do_prog(SEL_BASE, 4'd9);
    #1;
    check_idle("prog base");
    do_start(INT_DOUBLE_BASE);
    #1;
    check("double base load", 32'(bus.seconds_left), 32'd18);
    run_count("double base", 18);

    // Abort at cycle 5 of a base count by reprogramming base to 5
    do_start(INT_BASE);
    for (int k = 1; k < 5; k++) next_cycle();
    #1;
    check("abort pre sl", 32'(bus.seconds_left), 32'd8);
    bus.reprogram               = 1'b1;
    bus.time_parameter_selector = SEL_BASE;
    bus.time_value              = 4'd5;
    #1;
    check("abort cycle expired", 32'(bus.expired), 32'd0);
    next_cycle();
    bus.reprogram = 1'b0;
    #1;
    check_idle("abort");
    watch_no_pulse("abort", 40);
    do_start(INT_BASE);
    run_count("new base 5", 5);

    // Ignored writes: reserved selector and zero values
    do_prog(SEL_RESERVED, 4'd7);
    do_prog(SEL_EXTENDED, 4'd0);
    do_prog(SEL_YELLOW, 4'd0);
    do_prog(SEL_BASE, 4'd0);
    do_start(INT_BASE);
    run_count("keep base", 5);
    do_start(INT_EXTENDED);
    run_count("keep extended", 3);
    do_start(INT_YELLOW);
    run_count("keep yellow", 2);

    // Restart at cycle 10 of a 6 s base count
    do_prog(SEL_BASE, 4'd6);
    do_start(INT_BASE);
    for (int k = 1; k < 10; k++) next_cycle();
    #1;
    check("restart pre sl", 32'(bus.seconds_left), 32'd4);
    do_start(INT_BASE);
    run_count("restart", 6);
    watch_no_pulse("restart", 30);

    // Reprogram and start together: reprogram wins
    bus.reprogram               = 1'b1;
    bus.time_parameter_selector = SEL_YELLOW;
    bus.time_value              = 4'd4;
    bus.start_timer             = 1'b1;
    bus.interval_select         = INT_YELLOW;
    next_cycle();
    bus.reprogram   = 1'b0;
    bus.start_timer = 1'b0;
    #1;
    check_idle("prog+start");
    do_start(INT_YELLOW);
    run_count("yellow 4", 4);

    // Reset mid-count after extended = 7 restores extended to 3
    do_prog(SEL_EXTENDED, 4'd7);
    do_start(INT_EXTENDED);
    #1;
    check("ext 7 load", 32'(bus.seconds_left), 32'd7);
    for (int k = 1; k < 6; k++) next_cycle();
    reset = 1'b1;
    #1;
    check("reset cycle expired", 32'(bus.expired), 32'd0);
    next_cycle();
    reset = 1'b0;
    #1;
    check_idle("mid reset");
    do_start(INT_EXTENDED);
    run_count("extended default", 3);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  // Global time bound so a stuck run still terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
